// File: rtl/bus_pkg.sv
// bus_pkg: shared definitions for the round-robin bus arbiter.
//   BUS_ADDR_W / BUS_DATA_W : default bus widths
//   arb_state_t             : arbiter FSM state encoding
package bus_pkg;

    localparam int unsigned BUS_ADDR_W = 16;
    localparam int unsigned BUS_DATA_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY    = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: bundles the per-master request bus, the single slave bus
// and the arbiter status signals.
//   m_*          : per-master request/response (vectors indexed by master)
//   s_*          : shared slave-side request/response
//   grant, err   : one-hot grant and timeout pulse
// Modports:
//   slave  : arbiter view (consumes master requests, drives the slave bus)
//   master : environment view (the masters plus the slave)
interface bus_arbiter_if
    import bus_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned ADDR_W      = BUS_ADDR_W,
    parameter int unsigned DATA_W      = BUS_DATA_W
) ();

    logic [NUM_MASTERS-1:0]             m_valid;
    logic [NUM_MASTERS-1:0]             m_read;
    logic [NUM_MASTERS-1:0]             m_write;
    logic [NUM_MASTERS-1:0][ADDR_W-1:0] m_addr;
    logic [NUM_MASTERS-1:0][DATA_W-1:0] m_wdata;
    logic [NUM_MASTERS-1:0]             m_ready;
    logic [DATA_W-1:0]                  m_rdata;

    logic                               s_valid;
    logic                               s_read;
    logic                               s_write;
    logic [ADDR_W-1:0]                  s_addr;
    logic [DATA_W-1:0]                  s_wdata;
    logic                               s_ready;
    logic [DATA_W-1:0]                  s_rdata;

    logic [NUM_MASTERS-1:0]             grant;
    logic                               err;

    modport slave (
        input  m_valid, m_read, m_write, m_addr, m_wdata, s_ready, s_rdata,
        output m_ready, m_rdata, s_valid, s_read, s_write, s_addr, s_wdata,
               grant, err
    );

    modport master (
        output m_valid, m_read, m_write, m_addr, m_wdata, s_ready, s_rdata,
        input  m_ready, m_rdata, s_valid, s_read, s_write, s_addr, s_wdata,
               grant, err
    );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// rr_picker: combinational round-robin winner selection.
//   i_req      : request vector
//   i_last     : index of the previous winner; search starts at i_last+1
//   o_winner_c : one-hot winner (zero when no request)
//   o_idx_c    : winner index
//   o_none_c   : no request pending
module rr_picker #(
    parameter int unsigned N = 4,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [N-1:0]     o_winner_c,
    output logic [IDX_W-1:0] o_idx_c,
    output logic             o_none_c
);

    // Walk candidates last+1 .. last+N (mod N); the first requester wins.
    always_comb begin
        o_winner_c = '0;
        o_idx_c    = '0;
        o_none_c   = 1'b1;
        for (int unsigned k = 1; k <= N; k++) begin
            if (o_none_c && i_req[IDX_W'((32'(i_last) + k) % N)]) begin
                o_none_c = 1'b0;
                o_idx_c  = IDX_W'((32'(i_last) + k) % N);
            end
        end
        if (!o_none_c) begin
            o_winner_c[o_idx_c] = 1'b1;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter sharing one slave bus between
// NUM_MASTERS masters. IDLE picks a winner, BUSY muxes the winner onto the
// slave bus until s_ready (or abort), RELEASE inserts one dead cycle.
//   clk, reset : clock and synchronous active-high reset
//   bus        : bus_arbiter_if.slave (master requests, slave bus, grant, err)
// Optional feature macro: BUS_ARB_TIMEOUT_EN -- abort BUSY after TIMEOUT
// cycles without s_ready and pulse err; otherwise err is tied to 0.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned ADDR_W      = BUS_ADDR_W,
    parameter int unsigned DATA_W      = BUS_DATA_W,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic          clk,
    input  logic          reset,
    bus_arbiter_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(NUM_MASTERS);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_num_masters
        $error("bus_arbiter: NUM_MASTERS must be 2..8");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("bus_arbiter: TIMEOUT must be at least 1");
    end

    arb_state_t             r_state;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [IDX_W-1:0]       r_last;

    arb_state_t             w_state_nxt;
    logic [NUM_MASTERS-1:0] w_grant_nxt;
    logic [IDX_W-1:0]       w_last_nxt;

    logic [NUM_MASTERS-1:0] w_winner;
    logic [IDX_W-1:0]       w_win_idx;
    logic                   w_none;

    logic                   w_s_valid;
    logic                   w_s_read;
    logic                   w_s_write;
    logic [ADDR_W-1:0]      w_s_addr;
    logic [DATA_W-1:0]      w_s_wdata;
    logic [NUM_MASTERS-1:0] w_m_ready;
    logic [DATA_W-1:0]      w_m_rdata;
    logic                   w_err;

`ifdef BUS_ARB_TIMEOUT_EN
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
`endif

    rr_picker #(.N(NUM_MASTERS)) u_picker (
        .i_req      (bus.m_valid),
        .i_last     (r_last),
        .o_winner_c (w_winner),
        .o_idx_c    (w_win_idx),
        .o_none_c   (w_none)
    );

    // State, grant and round-robin pointer; pointer resets so master 0 wins first.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
            r_last  <= IDX_W'(NUM_MASTERS - 1);
`ifdef BUS_ARB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
`ifdef BUS_ARB_TIMEOUT_EN
            r_cnt   <= w_cnt_nxt;
`endif
        end
    end

    // Next state and slave/master side muxing; r_last is the granted index in BUSY.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        w_s_valid   = 1'b0;
        w_s_read    = 1'b0;
        w_s_write   = 1'b0;
        w_s_addr    = '0;
        w_s_wdata   = '0;
        w_m_ready   = '0;
        w_m_rdata   = '0;
        w_err       = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
        w_cnt_nxt   = r_cnt;
`endif
        unique case (r_state)
            ARB_IDLE: begin
                if (!w_none) begin
                    w_grant_nxt = w_winner;
                    w_last_nxt  = w_win_idx;
                    w_state_nxt = ARB_BUSY;
`ifdef BUS_ARB_TIMEOUT_EN
                    w_cnt_nxt   = '0;
`endif
                end
            end
            ARB_BUSY: begin
                w_s_valid = bus.m_valid[r_last];
                w_s_read  = bus.m_read[r_last];
                w_s_write = bus.m_write[r_last];
                w_s_addr  = bus.m_addr[r_last];
                w_s_wdata = bus.m_wdata[r_last];
                w_m_rdata = bus.s_rdata;
                // Completion is suppressed while reset is pending or the master has withdrawn.
                if (!reset && w_s_valid && bus.s_ready) begin
                    w_m_ready = r_grant;
                end
                if ((w_s_valid && bus.s_ready) || !w_s_valid) begin
                    w_grant_nxt = '0;
                    w_state_nxt = ARB_RELEASE;
                end
`ifdef BUS_ARB_TIMEOUT_EN
                else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_err       = !reset;
                    w_grant_nxt = '0;
                    w_state_nxt = ARB_RELEASE;
                end else if (r_cnt != '1) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
`endif
            end
            ARB_RELEASE: begin
                w_grant_nxt = '0;
                w_state_nxt = ARB_IDLE;
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    assign bus.s_valid = w_s_valid;
    assign bus.s_read  = w_s_read;
    assign bus.s_write = w_s_write;
    assign bus.s_addr  = w_s_addr;
    assign bus.s_wdata = w_s_wdata;
    assign bus.m_ready = w_m_ready;
    assign bus.m_rdata = w_m_rdata;
    assign bus.grant   = r_grant;
    assign bus.err     = w_err;

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares the single-slave parallel bus (16-bit address, 32-bit data, valid/ready handshake, read/write strobes) between `NUM_MASTERS` bus masters. Each master presents a request exactly as it would to the slave directly. The arbiter grants one master at a time, multiplexes that master's request onto the slave side, and routes `ready`/`read_data` back. It sits between the master register blocks and the slave, and is the only driver of the slave-side bus.

## Interface
Parameters:
- `NUM_MASTERS`, 4: number of requesters; legal range 2–8.
- `ADDR_W`, 16: address width.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 16: maximum cycles in BUSY without `s_ready`. Used only when `BUS_ARB_TIMEOUT_EN` is defined.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `m_valid` in `NUM_MASTERS`: per-master request valid.
- `m_read` / `m_write` in `NUM_MASTERS` each: per-master strobes.
- `m_addr` in `NUM_MASTERS`×`ADDR_W`: per-master address.
- `m_wdata` in `NUM_MASTERS`×`DATA_W`: per-master write data.
- `m_ready` out `NUM_MASTERS`: per-master completion, one-hot or zero.
- `m_rdata` out `DATA_W`: read data, broadcast to all masters.
- `s_valid`, `s_read`, `s_write` out 1 each: slave-side request.
- `s_addr` out `ADDR_W`; `s_wdata` out `DATA_W`.
- `s_ready` in 1: slave completion.
- `s_rdata` in `DATA_W`: slave read data.
- `grant` out `NUM_MASTERS`: registered one-hot grant vector.
- `err` out 1: one-cycle timeout pulse.

## Operation
- States: `ARB_IDLE`, `ARB_BUSY`, `ARB_RELEASE`.
- **IDLE**
  - If any `m_valid` is set, select the winner round-robin.
  - The search starts at `last_grant+1` mod `NUM_MASTERS`.
  - Register `grant`, update `last_grant`, then go to BUSY.
- **BUSY**
  - `s_valid/s_read/s_write/s_addr/s_wdata` are a combinational mux of the granted master's inputs.
  - `m_ready[g] = s_ready`; all other `m_ready` bits are 0.
  - `m_rdata = s_rdata`.
  - `s_valid & s_ready`: transaction complete; go to RELEASE.
  - Granted `m_valid` drops before `s_ready` (protocol violation): abort; go to RELEASE with no `m_ready`.
- **RELEASE**
  - `grant` is cleared; the slave side is idle.
  - Always go to IDLE next cycle. This guarantees one dead cycle between owners.
- Outside BUSY:
  - All `s_*` outputs and `m_ready` are 0.
  - `s_addr`/`s_wdata` are 0, not don't-care.
- `s_read`/`s_write` are passed through unmodified; the arbiter does not interpret transaction type.
- Masters must hold `m_valid` and their fields stable until they see their `m_ready`.
- Requests from non-granted masters are ignored, not queued; they win later by round-robin.
- Reset:
  - `state=ARB_IDLE`, `grant=0`, `last_grant=NUM_MASTERS-1` (master 0 wins first), `err=0`.
  - All `s_*` and `m_ready` outputs are 0.
- `reset` mid-BUSY aborts immediately: no `m_ready` pulse, and the slave sees `s_valid` fall the next cycle.

## Timing
- Grant latency: `m_valid` sampled in IDLE at edge N; `grant` and `s_valid` high during cycle N+1.
- Completion: `s_ready` in cycle K produces `m_ready[g]` in the same cycle K (combinational); `grant` is 0 in cycle K+1 (RELEASE).
- Minimum period per transaction: 3 cycles (IDLE, BUSY with immediate `s_ready`, RELEASE).
- Back-to-back requests from all masters are served strictly in order g, g+1, ... mod N, so no master waits more than N transactions.
- `s_ready` seen outside BUSY is ignored.

## Configuration
- `BUS_ARB_TIMEOUT_EN` defined:
  - A cycle counter is cleared on entry to BUSY and increments each BUSY cycle without `s_ready`.
  - When it reaches `TIMEOUT`: `err`=1 for that single cycle, no `m_ready`, go to RELEASE.
  - The counter is `$clog2(TIMEOUT+1)` bits wide and saturates rather than wrapping.
- Undefined: no counter is built, BUSY waits indefinitely for `s_ready`, and `err` is tied to 0. The port list is identical in both builds.

## Structure
- Shared package `bus_pkg`:
  - `ADDR_W`/`DATA_W` defaults.
  - `arb_state_t` enum (`ARB_IDLE`, `ARB_BUSY`, `ARB_RELEASE`) as `logic [1:0]`.
- Sub-module `rr_picker`:
  - Purely combinational.
  - Inputs: request vector and `last_grant` index.
  - Outputs: one-hot winner plus its index; `none` flag when there are no requests.
- `bus_arbiter` holds the FSM, grant register, mux, and optional timeout counter.

## Test plan
- Reset, then master 0 alone writes addr 0x0010 data 0xDEADBEEF with `s_ready` 1 cycle later -> `grant`=0001, `s_addr`=0x0010, `s_wdata`=0xDEADBEEF, `m_ready[0]` pulses once.
- All 4 masters request continuously -> grants in order 0,1,2,3,0, each separated by one RELEASE cycle with `grant`=0.
- Master 2 reads addr 0x0020 while slave returns `s_rdata`=0x12345678 -> `m_rdata`=0x12345678 with `m_ready[2]`; `m_ready[0,1,3]` remain 0.
- Assert `reset` during BUSY with master 1 granted -> next cycle `grant`=0, `s_valid`=0, no `m_ready`; first post-reset request from masters 0 and 1 grants master 0.
- With `BUS_ARB_TIMEOUT_EN`, `TIMEOUT`=16, slave never ready -> `err` pulses exactly at the 16th BUSY cycle, then RELEASE, then the next requester is granted.
- Granted master drops `m_valid` before `s_ready` -> RELEASE next cycle, no `m_ready`, and `last_grant` still points at that master.
